// File: rtl/rf_writeback_queue_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rf_writeback_queue_if : ALU/load result handshakes and RF write port   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface rf_writeback_queue_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_d_addr;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_d_addr;
  logic [DATA_W-1:0] mem_data;
  logic              rf_stall;
  logic              rf_rw;
  logic [ADDR_W-1:0] rf_d_addr;
  logic [DATA_W-1:0] rf_data;

  modport master (
    output alu_valid, alu_d_addr, alu_data,
    output mem_valid, mem_d_addr, mem_data,
    output rf_stall,
    input  alu_ready, mem_ready,
    input  rf_rw, rf_d_addr, rf_data
  );

  modport slave (
    input  alu_valid, alu_d_addr, alu_data,
    input  mem_valid, mem_d_addr, mem_data,
    input  rf_stall,
    output alu_ready, mem_ready,
    output rf_rw, rf_d_addr, rf_data
  );
endinterface
`default_nettype wire

// File: rtl/rf_writeback_queue.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rf_writeback_queue : FIFO of ALU/load results issuing one RF write per |
// | cycle, with RAW scoreboard. Optional forwarding search: WB_FWD_EN.     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module rf_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  rf_writeback_queue_if.slave         wb,
  output logic [(1<<ADDR_W)-1:0]      busy_o,
  output logic [$clog2(DEPTH):0]      count_o,
  input  wire logic [ADDR_W-1:0]      fwd_addr_i,
  output logic                        fwd_hit_o,
  output logic [DATA_W-1:0]           fwd_data_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              rf_rw_q;
  logic [ADDR_W-1:0] rf_d_addr_q;
  logic [DATA_W-1:0] rf_data_q;

  logic              full_w;
  logic              push_w;
  logic              pop_w;
  logic [ADDR_W-1:0] in_addr_w;
  logic [DATA_W-1:0] in_data_w;

  // Ready ignores a same-cycle pop so it never depends on rf_stall.
  assign full_w       = (count_q == C_DEPTH);
  assign wb.mem_ready = !full_w;
  assign wb.alu_ready = !full_w && !wb.mem_valid;
  assign push_w       = !full_w && (wb.mem_valid || wb.alu_valid);
  assign pop_w        = (count_q != '0) && !wb.rf_stall;
  assign in_addr_w    = wb.mem_valid ? wb.mem_d_addr : wb.alu_d_addr;
  assign in_data_w    = wb.mem_valid ? wb.mem_data   : wb.alu_data;

  assign wr_ptr_d = wr_ptr_q + PTR_W'(push_w);
  assign rd_ptr_d = rd_ptr_q + PTR_W'(pop_w);
  assign count_d  = count_q + CNT_W'(push_w) - CNT_W'(pop_w);

  always_comb begin
    vld_d = vld_q;
    if (pop_w)  vld_d[rd_ptr_q] = 1'b0;
    if (push_w) vld_d[wr_ptr_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      vld_q       <= '0;
      rf_rw_q     <= 1'b0;
      rf_d_addr_q <= '0;
      rf_data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      vld_q    <= vld_d;
      rf_rw_q  <= pop_w;
      if (pop_w) begin
        rf_d_addr_q <= addr_q[rd_ptr_q];
        rf_data_q   <= data_q[rd_ptr_q];
      end
    end
  end

  // Payload storage needs no reset; occupancy is tracked by vld_q.
  always_ff @(posedge clk) begin
    if (push_w) begin
      addr_q[wr_ptr_q] <= in_addr_w;
      data_q[wr_ptr_q] <= in_data_w;
    end
  end

  assign wb.rf_rw     = rf_rw_q;
  assign wb.rf_d_addr = rf_d_addr_q;
  assign wb.rf_data   = rf_data_q;
  assign count_o      = count_q;

  always_comb begin
    busy_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i]) busy_o[addr_q[i]] = 1'b1;
    end
    if (rf_rw_q) busy_o[rf_d_addr_q] = 1'b1;
  end

`ifdef WB_FWD_EN
  logic [PTR_W-1:0] fwd_idx_w;

  // Walk oldest to youngest so the youngest match overwrites earlier ones.
  always_comb begin
    fwd_idx_w  = '0;
    fwd_hit_o  = rf_rw_q && (rf_d_addr_q == fwd_addr_i);
    fwd_data_o = fwd_hit_o ? rf_data_q : '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx_w = rd_ptr_q + PTR_W'(k);
      if (vld_q[fwd_idx_w] && (addr_q[fwd_idx_w] == fwd_addr_i)) begin
        fwd_hit_o  = 1'b1;
        fwd_data_o = data_q[fwd_idx_w];
      end
    end
  end
`else
  logic unused_fwd_w;
  assign unused_fwd_w = ^fwd_addr_i;
  assign fwd_hit_o    = 1'b0;
  assign fwd_data_o   = '0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_rf_writeback_queue.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_rf_writeback_queue : directed scenarios plus randomized traffic     |
// | against a queue-based reference model. Rev 1.0                        |
// +-----------------------------------------------------------------------+
module tb_rf_writeback_queue;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 32;
`ifdef WB_FWD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREG-1:0]   busy;
  logic [2:0]        count;
  logic [ADDR_W-1:0] fwd_addr = '0;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  rf_writeback_queue_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) wb ();

  rf_writeback_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .wb         (wb.slave),
    .busy_o     (busy),
    .count_o    (count),
    .fwd_addr_i (fwd_addr),
    .fwd_hit_o  (fwd_hit),
    .fwd_data_o (fwd_data)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  ent_t              mq[$];
  logic              exp_rw   = 1'b0;
  logic [ADDR_W-1:0] exp_addr = '0;
  logic [DATA_W-1:0] exp_data = '0;
  logic [DATA_W-1:0] model_rf [NREG];
  logic [DATA_W-1:0] obs_rf   [NREG];
  logic [NREG-1:0]   written  = '0;

  // Register file view: samples on the negedge inside the rf_rw cycle.
  always @(negedge clk) begin
    if (wb.rf_rw === 1'b1) obs_rf[wb.rf_d_addr] = wb.rf_data;
  end

  task automatic drive(input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                       input logic mv, input logic [ADDR_W-1:0] ma, input logic [DATA_W-1:0] md,
                       input logic st);
    wb.alu_valid = av; wb.alu_d_addr = aa; wb.alu_data = ad;
    wb.mem_valid = mv; wb.mem_d_addr = ma; wb.mem_data = md;
    wb.rf_stall  = st;
  endtask

  task automatic reset_model();
    mq.delete();
    exp_rw = 1'b0; exp_addr = '0; exp_data = '0;
  endtask

  // Advance one clock: model applies the queue rules at the edge, returns at next negedge.
  task automatic tick();
    bit   acc, pop;
    ent_t e_in, e_out;
    acc  = (wb.mem_valid || wb.alu_valid) && (mq.size() < DEPTH);
    e_in = wb.mem_valid ? ent_t'{a: wb.mem_d_addr, d: wb.mem_data}
                        : ent_t'{a: wb.alu_d_addr, d: wb.alu_data};
    pop  = (mq.size() != 0) && !wb.rf_stall;
    @(posedge clk);
    if (pop) begin
      e_out = mq.pop_front();
      exp_rw = 1'b1; exp_addr = e_out.a; exp_data = e_out.d;
      model_rf[e_out.a] = e_out.d; written[e_out.a] = 1'b1;
    end else begin
      exp_rw = 1'b0;
    end
    if (acc) mq.push_back(e_in);
    @(negedge clk);
  endtask

  function automatic logic [NREG-1:0] exp_busy();
    logic [NREG-1:0] b;
    b = '0;
    foreach (mq[i]) b[mq[i].a] = 1'b1;
    if (exp_rw) b[exp_addr] = 1'b1;
    return b;
  endfunction

  function automatic logic [DATA_W:0] exp_fwd(input logic [ADDR_W-1:0] a);
    if (FWD_ON) begin
      for (int i = int'(mq.size()) - 1; i >= 0; i--)
        if (mq[i].a == a) return {1'b1, mq[i].d};
      if (exp_rw && exp_addr == a) return {1'b1, exp_data};
    end
    return '0;
  endfunction

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    reset_model();
    #1;
    n_chk++; if ({wb.rf_rw, wb.rf_d_addr, wb.rf_data, count} !== '0) begin n_fail++;
      $display("FAIL reset_state: rw=%0b addr=%0d data=%h count=%0d want all 0", wb.rf_rw, wb.rf_d_addr, wb.rf_data, count); end
    n_chk++; if ({busy, wb.alu_ready, wb.mem_ready} !== {32'h0, 2'b11}) begin n_fail++;
      $display("FAIL reset_busy_ready: busy=%h alu_rdy=%0b mem_rdy=%0b want 0,1,1", busy, wb.alu_ready, wb.mem_ready); end
    for (int i = 1; i <= 3; i++) begin
      drive(1, 5'(i), 32'h100 + i, 0, 0, 0, 1);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    n_chk++; if (count !== 3'd3) begin n_fail++; $display("FAIL reset_fill_count: got %0d want 3", count); end
    #2 rst = 1'b1;
    #1;
    n_chk++; if ({wb.rf_rw, count, busy} !== '0) begin n_fail++;
      $display("FAIL reset_async: rw=%0b count=%0d busy=%h want 0", wb.rf_rw, count, busy); end
    reset_model();
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      n_chk++; if (wb.rf_rw !== 1'b0) begin n_fail++; $display("FAIL reset_no_late_write: rf_rw=%0b want 0", wb.rf_rw); end
    end
  endtask

  task automatic test_basic();
    drive(1, 5'd5, 32'h1234, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    n_chk++; if ({wb.rf_rw, count, busy[5]} !== {1'b0, 3'd1, 1'b1}) begin n_fail++;
      $display("FAIL basic_edge1: rw=%0b count=%0d busy5=%0b want 0,1,1", wb.rf_rw, count, busy[5]); end
    tick();
    n_chk++; if ({wb.rf_rw, wb.rf_d_addr, wb.rf_data, busy[5]} !== {1'b1, 5'd5, 32'h1234, 1'b1}) begin n_fail++;
      $display("FAIL basic_edge2: rw=%0b addr=%0d data=%h busy5=%0b want 1,5,1234,1", wb.rf_rw, wb.rf_d_addr, wb.rf_data, busy[5]); end
    tick();
    n_chk++; if ({wb.rf_rw, busy[5], count} !== '0) begin n_fail++;
      $display("FAIL basic_edge3: rw=%0b busy5=%0b count=%0d want 0,0,0", wb.rf_rw, busy[5], count); end
  endtask

  task automatic test_priority();
    drive(1, 5'd3, 32'hA, 1, 5'd4, 32'hB, 0);
    #1;
    n_chk++; if ({wb.mem_ready, wb.alu_ready} !== 2'b10) begin n_fail++;
      $display("FAIL prio_ready: mem=%0b alu=%0b want 1,0", wb.mem_ready, wb.alu_ready); end
    tick();
    drive(1, 5'd3, 32'hA, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    n_chk++; if ({wb.rf_rw, wb.rf_d_addr, wb.rf_data} !== {1'b1, 5'd4, 32'hB}) begin n_fail++;
      $display("FAIL prio_first: rw=%0b addr=%0d data=%h want 1,4,b", wb.rf_rw, wb.rf_d_addr, wb.rf_data); end
    tick();
    n_chk++; if ({wb.rf_rw, wb.rf_d_addr, wb.rf_data} !== {1'b1, 5'd3, 32'hA}) begin n_fail++;
      $display("FAIL prio_second: rw=%0b addr=%0d data=%h want 1,3,a", wb.rf_rw, wb.rf_d_addr, wb.rf_data); end
    tick();
  endtask

  task automatic test_stall_fill();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 5'(10 + i), 32'hC0DE_0000 + i, 1);
      tick();
    end
    drive(1, 5'd1, 32'h1, 1, 5'd2, 32'h2, 1);
    #1;
    n_chk++; if ({count, wb.alu_ready, wb.mem_ready, wb.rf_rw} !== {3'd4, 3'b000}) begin n_fail++;
      $display("FAIL stall_full: count=%0d alu=%0b mem=%0b rw=%0b want 4,0,0,0", count, wb.alu_ready, wb.mem_ready, wb.rf_rw); end
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++; if ({wb.rf_rw, wb.rf_d_addr, wb.rf_data} !== {1'b1, 5'(10 + i), 32'hC0DE_0000 + i}) begin n_fail++;
        $display("FAIL stall_drain[%0d]: rw=%0b addr=%0d data=%h want 1,%0d", i, wb.rf_rw, wb.rf_d_addr, wb.rf_data, 10 + i); end
    end
    tick();
    n_chk++; if ({wb.rf_rw, count} !== 4'b0) begin n_fail++;
      $display("FAIL stall_done: rw=%0b count=%0d want 0,0", wb.rf_rw, count); end
  endtask

  task automatic test_full_throughput();
    int nxt;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 5'(16 + i), 32'hF000_0000 | (16 + i), 1);
      tick();
    end
    nxt = 20;
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 1, 5'(nxt), 32'hF000_0000 | nxt, 0);
      #1;
      n_chk++; if (wb.mem_ready !== (i != 0)) begin n_fail++;
        $display("FAIL thru_ready[%0d]: mem_ready=%0b want %0b", i, wb.mem_ready, i != 0); end
      tick();
      n_chk++; if ({wb.rf_rw, wb.rf_d_addr, wb.rf_data, count} !== {1'b1, 5'(16 + i), 32'hF000_0000 | (16 + i), 3'd3}) begin n_fail++;
        $display("FAIL thru_pop[%0d]: rw=%0b addr=%0d count=%0d want 1,%0d,3", i, wb.rf_rw, wb.rf_d_addr, count, 16 + i); end
      if (i != 0) nxt++;
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++; if ({wb.rf_rw, wb.rf_d_addr} !== {1'b1, 5'(24 + i)}) begin n_fail++;
        $display("FAIL thru_drain[%0d]: rw=%0b addr=%0d want 1,%0d", i, wb.rf_rw, wb.rf_d_addr, 24 + i); end
    end
    tick();
    n_chk++; if (count !== 3'd0) begin n_fail++; $display("FAIL thru_empty: count=%0d want 0", count); end
  endtask

  task automatic test_fwd();
    logic [DATA_W:0] want;
    want = FWD_ON ? {1'b1, 32'h2} : '0;
    drive(1, 5'd7, 32'h1, 0, 0, 0, 1); tick();
    drive(1, 5'd7, 32'h2, 0, 0, 0, 1); tick();
    drive(0, 0, 0, 0, 0, 0, 1);
    fwd_addr = 5'd7; #1;
    n_chk++; if ({fwd_hit, fwd_data} !== want) begin n_fail++;
      $display("FAIL fwd_queued: hit=%0b data=%h want %h", fwd_hit, fwd_data, want); end
    fwd_addr = 5'd8; #1;
    n_chk++; if ({fwd_hit, fwd_data} !== 33'h0) begin n_fail++;
      $display("FAIL fwd_miss: hit=%0b data=%h want 0", fwd_hit, fwd_data); end
    fwd_addr = 5'd7;
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_chk++; if ({fwd_hit, fwd_data} !== want) begin n_fail++;
        $display("FAIL fwd_issue[%0d]: hit=%0b data=%h want %h", i, fwd_hit, fwd_data, want); end
    end
    tick();
    n_chk++; if (fwd_hit !== 1'b0) begin n_fail++; $display("FAIL fwd_gone: hit=%0b want 0", fwd_hit); end
  endtask

  task automatic test_random();
    logic [DATA_W:0] wf;
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 9) < 3));
      fwd_addr = 5'($urandom_range(0, 7));
      #1;
      n_chk++; if ({wb.mem_ready, wb.alu_ready} !== {mq.size() < DEPTH, (mq.size() < DEPTH) && !wb.mem_valid}) begin n_fail++;
        $display("FAIL rand_ready[%0d]: mem=%0b alu=%0b qsize=%0d", c, wb.mem_ready, wb.alu_ready, mq.size()); end
      wf = exp_fwd(fwd_addr);
      n_chk++; if ({fwd_hit, fwd_data} !== wf) begin n_fail++;
        $display("FAIL rand_fwd[%0d]: got %0b/%h want %h", c, fwd_hit, fwd_data, wf); end
      tick();
      n_chk++; if ({wb.rf_rw, wb.rf_d_addr, wb.rf_data} !== {exp_rw, exp_addr, exp_data}) begin n_fail++;
        $display("FAIL rand_rf[%0d]: got %0b,%0d,%h want %0b,%0d,%h", c, wb.rf_rw, wb.rf_d_addr, wb.rf_data, exp_rw, exp_addr, exp_data); end
      n_chk++; if ({count, busy} !== {3'(mq.size()), exp_busy()}) begin n_fail++;
        $display("FAIL rand_state[%0d]: count=%0d busy=%h want %0d,%h", c, count, busy, mq.size(), exp_busy()); end
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (DEPTH + 2) tick();
    for (int r = 0; r < NREG; r++) begin
      if (written[r]) begin
        n_chk++; if (obs_rf[r] !== model_rf[r]) begin n_fail++;
          $display("FAIL rand_regfile[%0d]: got %h want %h", r, obs_rf[r], model_rf[r]); end
      end
    end
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_basic();
    test_priority();
    test_stall_fill();
    test_full_throughput();
    test_fwd();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
